// File: rtl/dmem_arbiter.sv
// Two-master Data Memory arbiter for core and debug module, with starvation relief and 1-cycle responses.
// Optional DMEM_ARB_RANGE_CHECK_EN rejects debug accesses at or above DM_ADDR_LIMIT with an error response.
module dmem_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter logic [31:0] DM_ADDR_LIMIT = 32'h0000_0400
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [31:0]       dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_err_o,
  input  logic              core_halted_i,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] DM_LIMIT   = ADDR_W'(DM_ADDR_LIMIT);
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {OWN_IDLE, OWN_CORE, OWN_DM} owner_e;

  owner_e      owner_q, owner_d;
  logic [3:0]  starve_cnt, starve_d;
  logic [31:0] core_rdata_q, dm_rdata_q;
  logic        dm_err_q;
  logic        dm_wins, core_gnt, dm_gnt, dm_oob;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    owner_d     = OWN_IDLE;
    starve_d    = starve_cnt;

    dm_wins  = dm_req_i && (core_halted_i || !core_req_i || (starve_cnt == STARVE_MAX));
    // Grants are gated by reset so nothing reaches memory while reset is held.
    dm_gnt   = reset_i && dm_wins;
    core_gnt = reset_i && core_req_i && !dm_wins;
    dm_oob   = RANGE_CHECK && (dm_addr_i >= DM_LIMIT);

    if (core_gnt) begin
      owner_d     = OWN_CORE;
      mem_read_o  = !core_we_i;
      mem_write_o = core_we_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end else if (dm_gnt) begin
      owner_d     = OWN_DM;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
      if (!dm_oob) begin
        mem_read_o  = !dm_we_i;
        mem_write_o = dm_we_i;
      end
    end

    if (!dm_req_i || dm_gnt) begin
      starve_d = 4'd0;
    end else if (starve_cnt < STARVE_MAX) begin
      starve_d = starve_cnt + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      owner_q      <= OWN_IDLE;
      starve_cnt   <= 4'd0;
      core_rdata_q <= 32'h0;
      dm_rdata_q   <= 32'h0;
      dm_err_q     <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      starve_cnt <= starve_d;
      dm_err_q   <= dm_gnt && dm_oob;
      if (core_gnt) begin
        core_rdata_q <= core_we_i ? 32'h0 : mem_rdata_i;
      end
      if (dm_gnt) begin
        dm_rdata_q <= (dm_we_i || dm_oob) ? 32'h0 : mem_rdata_i;
      end
    end
  end

  assign core_gnt_o    = core_gnt;
  assign dm_gnt_o      = dm_gnt;
  assign core_rvalid_o = (owner_q == OWN_CORE);
  assign dm_rvalid_o   = (owner_q == OWN_DM);
  assign core_rdata_o  = core_rdata_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign dm_err_o      = dm_err_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width of every address port.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning the consecutive lost cycles after which the debug requester is forced a grant (range 1..15).
REQ-003 SHALL have parameter DM_ADDR_LIMIT, default 32'h0000_0400, meaning the exclusive upper bound of legal debug byte addresses.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 reset_i  in  1  asynchronous active-low reset.
REQ-007 core_req_i / core_we_i  in  1/1  core access request / write (1) or read (0).
REQ-008 core_addr_i / core_wdata_i  in  ADDR_W/32  core address / store data.
REQ-009 core_gnt_o  out  1  core access accepted this cycle.
REQ-010 core_rvalid_o / core_rdata_o  out  1/32  core response strobe / load data.
REQ-011 dm_req_i / dm_we_i  in  1/1  debug-module request / write (1) or read (0).
REQ-012 dm_addr_i / dm_wdata_i  in  ADDR_W/32  debug address / write data.
REQ-013 dm_gnt_o  out  1  debug access accepted this cycle.
REQ-014 dm_rvalid_o / dm_rdata_o / dm_err_o  out  1/32/1  debug response strobe / read data / access error.
REQ-015 core_halted_i  in  1  core halted by debug module.
REQ-016 mem_read_o / mem_write_o  out  1/1  Data Memory read / write strobe.
REQ-017 mem_addr_o / mem_wdata_o  out  ADDR_W/32  Data Memory address / write data.
REQ-018 mem_rdata_i  in  32  Data Memory combinational read data.

Function
REQ-019 SHALL grant at most one requester per cycle; grant, mem strobes, mem_addr_o and mem_wdata_o are combinational from the current-cycle requests and registered state.
REQ-020 SHALL, with core_halted_i=1, give the debug requester fixed priority.
REQ-021 SHALL, with core_halted_i=0, give the core priority unless starve_cnt==STARVE_LIMIT, in which case the debug requester wins.
REQ-022 SHALL keep a 4-bit starve_cnt: +1 when dm_req_i=1 and dm_gnt_o=0, cleared on dm_gnt_o=1 or dm_req_i=0, saturating at STARVE_LIMIT.
REQ-023 SHALL, on a granted access, drive mem_read_o=~we, mem_write_o=we with the winner's address and data; with no grant all mem strobes SHALL be 0.
REQ-024 SHALL register the grant owner (IDLE, CORE, DM) and mem_rdata_i at the grant edge, asserting the owner's rvalid for exactly one cycle next cycle (1-cycle latency, writes included, rdata=0 for writes).
REQ-025 SHALL sustain one grant per cycle back-to-back, including alternating owners, without bubbles.
REQ-026 SHALL hold rdata outputs at their last value when rvalid is 0.
REQ-027 SHALL require requesters to hold request fields stable until granted; fields changing before grant are not latched.

Reset
REQ-028 SHALL, while reset_i=0, force core_gnt_o, dm_gnt_o, mem strobes, both rvalids, dm_err_o to 0, rdata registers to 32'h0, starve_cnt to 0, owner to IDLE.
REQ-029 SHALL discard an in-flight response when reset asserts mid-access; no rvalid after reset release without a new grant.

Configuration
REQ-030 SHALL, with DMEM_ARB_RANGE_CHECK_EN defined, grant a debug access with dm_addr_i>=DM_ADDR_LIMIT without driving mem strobes, then return dm_rvalid_o=1, dm_err_o=1, dm_rdata_o=0 next cycle.
REQ-031 SHALL, without DMEM_ARB_RANGE_CHECK_EN, forward every debug access to memory and tie dm_err_o to 0.

Verification
REQ-032 Halted, dm read addr 0x10, mem holds 0xDEADBEEF -> dm_gnt_o cycle N, dm_rvalid_o and dm_rdata_o=0xDEADBEEF cycle N+1.
REQ-033 Running, core_req_i and dm_req_i held high 6 cycles, STARVE_LIMIT=4 -> core granted cycles 0-3, dm granted cycle 4, core cycle 5.
REQ-034 Core write 0x20=0x12345678 then read 0x20 back-to-back -> grants N, N+1; core_rvalid_o N+1, N+2; read data 0x12345678.
REQ-035 Range check on, dm read 0x400 -> no mem strobe, dm_err_o=1, dm_rdata_o=0 next cycle; macro off -> mem_read_o=1, dm_err_o=0.
REQ-036 reset_i low in cycle after core read grant -> core_rvalid_o stays 0, all outputs at reset values, starve_cnt=0.
REQ-037 core_halted_i rising while both request -> dm granted same cycle halted seen high.
